// File: rtl/seqdet_pkg.sv
// Shared helpers for the parametrised Moore sequence detector.
package seqdet_pkg;

    localparam int unsigned DEFAULT_CNT_W = 8;
    localparam logic [DEFAULT_CNT_W-1:0] DEFAULT_CNT_MAX = {DEFAULT_CNT_W{1'b1}};

    // State encodes "k pattern bits matched", so it must reach W inclusive.
    function automatic int state_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Stream, control and status bundle for moore_seq_detector.
interface moore_seq_detector_if #(
    parameter int W     = 3,
    parameter int CNT_W = 8
);
    import seqdet_pkg::*;

    localparam int SW = state_width(W);

    logic             en;
    logic             x;
    logic             mode_overlap;
    logic             pat_load;
    logic [W-1:0]     pat_in;
    logic             out;
    logic [SW-1:0]    present;
    logic [CNT_W-1:0] match_count;

    modport master (
        output en, x, mode_overlap, pat_load, pat_in,
        input  out, present, match_count
    );

    modport slave (
        input  en, x, mode_overlap, pat_load, pat_in,
        output out, present, match_count
    );

endinterface

// File: rtl/seqdet_prefix_match.sv
// Finds the longest pattern prefix that is a suffix of the valid history.
module seqdet_prefix_match
    import seqdet_pkg::*;
#(
    parameter int W  = 3,
    parameter int SW = state_width(W)
) (
    input  logic [W-1:0]  h,
    input  logic [SW-1:0] v,
    input  logic [W-1:0]  pat,
    output logic [SW-1:0] k
);

    logic [W:1] hit;

    // One comparator per candidate length, all evaluated in parallel.
    for (genvar j = 1; j <= W; j++) begin : g_cmp
        assign hit[j] = (h[j-1:0] == pat[W-1 -: j]);
    end

    // Later iterations win, so this selects the largest qualifying length.
    always_comb begin
        k = '0;
        for (int i = 1; i <= W; i++) begin
            if (hit[i] && (i <= int'(v))) begin
                k = SW'(i);
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial sequence detector with runtime pattern, overlap mode and match counter.
module moore_seq_detector
    import seqdet_pkg::*;
#(
    parameter int           W       = 3,
    parameter logic [W-1:0] PATTERN = 3'b101,
    parameter int           CNT_W   = DEFAULT_CNT_W
) (
    input logic               clk,
    input logic               reset_n,
    moore_seq_detector_if.slave bus
);

    localparam int SW = state_width(W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SW-1:0]    S_FULL  = SW'(W);

    logic [W-1:0]     pat;
    logic [W-1:0]     hist;
    logic [SW-1:0]    hv;
    logic [SW-1:0]    present_q;
    logic [CNT_W-1:0] count_q;

    logic [W-1:0]  h_next;
    logic [SW-1:0] v_next;
    logic [SW-1:0] k_next;

    // Non-overlap mode restarts from just the newest bit after a match.
    always_comb begin
        h_next = {hist[W-2:0], bus.x};
        if ((present_q == S_FULL) && !bus.mode_overlap) begin
            v_next = SW'(1);
        end else if (hv == S_FULL) begin
            v_next = S_FULL;
        end else begin
            v_next = hv + SW'(1);
        end
    end

    seqdet_prefix_match #(
        .W  (W),
        .SW (SW)
    ) u_prefix (
        .h   (h_next),
        .v   (v_next),
        .pat (pat),
        .k   (k_next)
    );

    // Pattern load beats an accepted bit; otherwise everything holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat       <= PATTERN;
            hist      <= '0;
            hv        <= '0;
            present_q <= '0;
            count_q   <= '0;
        end else if (bus.pat_load) begin
            pat       <= bus.pat_in;
            hist      <= '0;
            hv        <= '0;
            present_q <= '0;
            count_q   <= '0;
        end else if (bus.en) begin
            hist      <= h_next;
            hv        <= v_next;
            present_q <= k_next;
            if ((k_next == S_FULL) && (count_q != CNT_MAX)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.present     = present_q;
    assign bus.out         = (present_q == S_FULL);
    assign bus.match_count = count_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed self-checking bench for moore_seq_detector across three parameter sets.
module tb_moore_seq_detector;

    typedef struct {
        logic       pat_load;
        logic       en;
        logic       x;
        logic       ovl;
        logic [2:0] pat_in;
        int         exp_present;
        int         exp_out;
        int         exp_count;
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    moore_seq_detector_if #(.W(3), .CNT_W(8)) bus3();
    moore_seq_detector_if #(.W(4), .CNT_W(8)) bus4();
    moore_seq_detector_if #(.W(2), .CNT_W(2)) bus2();

    moore_seq_detector #(.W(3), .PATTERN(3'b101), .CNT_W(8)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );
    moore_seq_detector #(.W(4), .PATTERN(4'b1101), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );
    moore_seq_detector #(.W(2), .PATTERN(2'b11), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic pl, input logic e, input logic xi, input logic o,
                                input logic [2:0] p, input int ep, input int eo, input int ec);
        vec_t v;
        v.pat_load    = pl;
        v.en          = e;
        v.x           = xi;
        v.ovl         = o;
        v.pat_in      = p;
        v.exp_present = ep;
        v.exp_out     = eo;
        v.exp_count   = ec;
        return v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        bus3.pat_load     = v.pat_load;
        bus3.en           = v.en;
        bus3.x            = v.x;
        bus3.mode_overlap = v.ovl;
        bus3.pat_in       = v.pat_in;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic xi, input int ep, input int eo, input int ec);
        @(negedge clk);
        bus4.en = 1'b1;
        bus4.x  = xi;
        @(posedge clk);
        #1;
        check_output("w4_present", int'(bus4.present), ep);
        check_output("w4_out", int'(bus4.out), eo);
        check_output("w4_count", int'(bus4.match_count), ec);
    endtask

    task automatic step2(input logic xi, input int ep, input int eo, input int ec);
        @(negedge clk);
        bus2.en = 1'b1;
        bus2.x  = xi;
        @(posedge clk);
        #1;
        check_output("w2_present", int'(bus2.present), ep);
        check_output("w2_out", int'(bus2.out), eo);
        check_output("w2_count", int'(bus2.match_count), ec);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        bus3.en = 1'b0; bus3.x = 1'b0; bus3.mode_overlap = 1'b1; bus3.pat_load = 1'b0; bus3.pat_in = '0;
        bus4.en = 1'b0; bus4.x = 1'b0; bus4.mode_overlap = 1'b1; bus4.pat_load = 1'b0; bus4.pat_in = '0;
        bus2.en = 1'b0; bus2.x = 1'b0; bus2.mode_overlap = 1'b1; bus2.pat_load = 1'b0; bus2.pat_in = '0;

        // Overlap stream 1,0,1,0,1 then the same stream without overlap.
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3'b000, 2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 3'b000, 2, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 3, 1, 2));
        vecs.push_back(mk(1, 1, 1, 0, 3'b101, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 3'b000, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 3'b000, 1, 0, 1));
        // Reload to 011 on the second bit, then 0,1,1 matches once.
        vecs.push_back(mk(1, 1, 0, 1, 3'b101, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3'b011, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 3, 1, 1));
        // Back to 101, match, idle five cycles, then a 0 falls back to state 2.
        vecs.push_back(mk(1, 0, 0, 1, 3'b101, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3'b000, 2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 3'b000, 3, 1, 1));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 3'b000, 3, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 3'b000, 2, 0, 1));

        #3;
        check_output("reset_present", int'(bus3.present), 0);
        check_output("reset_out", int'(bus3.out), 0);
        check_output("reset_count", int'(bus3.match_count), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("v%0d_present", i), int'(bus3.present), vecs[i].exp_present);
            check_output($sformatf("v%0d_out", i), int'(bus3.out), vecs[i].exp_out);
            check_output($sformatf("v%0d_count", i), int'(bus3.match_count), vecs[i].exp_count);
        end
        @(negedge clk);
        bus3.en = 1'b0;
        bus3.pat_load = 1'b0;

        // W=4, pattern 1101: KMP fallback to 2 after the first match.
        step4(1'b1, 1, 0, 0);
        step4(1'b1, 2, 0, 0);
        step4(1'b0, 3, 0, 0);
        step4(1'b1, 4, 1, 1);
        step4(1'b1, 2, 0, 1);
        step4(1'b0, 3, 0, 1);
        step4(1'b1, 4, 1, 2);
        @(negedge clk);
        bus4.en = 1'b0;

        // W=2, CNT_W=2, pattern 11: counter saturates at 3.
        step2(1'b1, 1, 0, 0);
        step2(1'b1, 2, 1, 1);
        step2(1'b1, 2, 1, 2);
        step2(1'b1, 2, 1, 3);
        step2(1'b1, 2, 1, 3);
        step2(1'b1, 2, 1, 3);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_w3_present", int'(bus3.present), 0);
        check_output("async_w3_count", int'(bus3.match_count), 0);
        check_output("async_w4_count", int'(bus4.match_count), 0);
        check_output("async_w2_present", int'(bus2.present), 0);
        check_output("async_w2_out", int'(bus2.out), 0);
        check_output("async_w2_count", int'(bus2.match_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus2.en = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
